dual_port_ram_param: RTL and testbench
======================================

DUAL_PORT_RAM_PARAM -- requirements
Module: dual_port_ram_param

Interface
REQ-001 Parameter DATA_W, default 8: data word width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 8: address width; depth = 2**ADDR_W words.
REQ-003 Parameter RD_MODE, default 2: same-port read-during-write behaviour; 0 = read-first, 1 = write-first, 2 = no-change.
REQ-004 Parameter OUT_REG, default 0: 1 adds one output pipeline stage per port.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 en_A, en_B  input  1  port access enable; no access when 0.
REQ-008 wr_en_A, wr_en_B  input  1  1 = write, 0 = read; qualified by en_x.
REQ-009 be_A, be_B  input  DATA_W/8  byte write enables; bit i gates bits [8i+7:8i].
REQ-010 addr_A, addr_B  input  ADDR_W  word address.
REQ-011 data_A, data_B  input  DATA_W  write data.
REQ-012 q_A, q_B  output  DATA_W  read data.
REQ-013 q_valid_A, q_valid_B  output  1  q_x holds data from a completed read this cycle.
REQ-014 coll_ww  output  1  one-cycle pulse: both ports wrote the same address.
REQ-015 coll_rw  output  1  one-cycle pulse: one port read an address the other port wrote in the same cycle.

Function
REQ-016 Write: en_x=1, wr_en_x=1 SHALL update only the bytes of ram[addr_x] whose be_x bit is 1 at the rising edge.
REQ-017 Read: en_x=1, wr_en_x=0 SHALL return ram[addr_x] on q_x with latency 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); q_valid_x SHALL be high for exactly one cycle, aligned with that data.
REQ-018 A write or idle cycle SHALL leave q_x unchanged and leave q_valid_x low, except as stated in REQ-019.
REQ-019 Same-port write, RD_MODE=0: q_x SHALL load the pre-write word. RD_MODE=1: q_x SHALL load the post-write merged word. RD_MODE=2: q_x SHALL hold its value. In modes 0 and 1, q_valid_x SHALL pulse with the same latency as a read.
REQ-020 Write-write collision (both ports write, addr_A==addr_B): bytes enabled on port A SHALL take data_A. Bytes enabled only on port B SHALL take data_B. coll_ww SHALL pulse high the following cycle.
REQ-021 Read-write collision (one port reads, the other writes the same address): the reader SHALL receive the pre-write word. coll_rw SHALL pulse high the following cycle.
REQ-022 Collision flags SHALL be registered, independent of OUT_REG, and evaluated only when both en_A and en_B are 1.
REQ-023 Address wrap: addresses are exactly ADDR_W bits; no out-of-range condition exists.
REQ-024 With OUT_REG=1, the pipeline stage SHALL advance every cycle without stalls. Back-to-back reads SHALL yield one result per cycle.

Reset
REQ-025 rst_n=0 SHALL immediately clear q_A, q_B, q_valid_A, q_valid_B, coll_ww, coll_rw and all pipeline registers to 0.
REQ-026 Memory contents SHALL NOT be cleared by reset; contents are undefined until written.
REQ-027 An access presented while rst_n=0 SHALL be discarded: no write and no read result.
REQ-028 A read in flight when reset asserts SHALL produce no q_valid after release.
REQ-029 The first access SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-030 Defaults: write A addr 0x10 = 0x5A, then read B addr 0x10 -> q_B = 0x5A with q_valid_B high, 1 cycle after the read edge.
REQ-031 DATA_W=32: write 0xAABBCCDD to addr 3, then write 0x11223344 with be=4'b0101, then read -> 0xAA22CC44.
REQ-032 Same-cycle write, addr 7: A = 0x01 be=1, B = 0x02 be=1 -> ram[7] = 0x01, coll_ww=1 for one cycle. A second case, DATA_W=16 with A be=2'b10, B be=2'b01 -> bytes merged, coll_ww=1.
REQ-033 RD_MODE 0/1/2: addr 5 holds 0x33; same-port write of 0x44 -> q = 0x33 / 0x44 / previous q respectively, with q_valid pulsing in modes 0 and 1 only.
REQ-034 OUT_REG=1: reads of addr 0,1,2 on consecutive cycles -> data on cycles +2,+3,+4 with q_valid continuous for 3 cycles. Then A reads addr 9 while B writes addr 9 -> A gets the old word and coll_rw pulses.
REQ-035 Assert rst_n low mid-read with OUT_REG=1 -> q and q_valid go 0 asynchronously. Release -> no stale q_valid, and memory still returns pre-reset contents.

Source files
------------

// File: rtl/dual_port_ram_param.sv
// True dual-port byte-writable RAM on a single clock, with selectable same-port
// read-during-write behaviour, optional output register and collision flags.
module dual_port_ram_param #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned RD_MODE = 2,
    parameter int unsigned OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_A,
    input  logic                  en_B,
    input  logic                  wr_en_A,
    input  logic                  wr_en_B,
    input  logic [DATA_W/8-1:0]   be_A,
    input  logic [DATA_W/8-1:0]   be_B,
    input  logic [ADDR_W-1:0]     addr_A,
    input  logic [ADDR_W-1:0]     addr_B,
    input  logic [DATA_W-1:0]     data_A,
    input  logic [DATA_W-1:0]     data_B,
    output logic [DATA_W-1:0]     q_A,
    output logic [DATA_W-1:0]     q_B,
    output logic                  q_valid_A,
    output logic                  q_valid_B,
    output logic                  coll_ww,
    output logic                  coll_rw
);

    localparam int unsigned NBYTES    = DATA_W / 8;
    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam int unsigned RD_FIRST  = 0;
    localparam int unsigned WR_FIRST  = 1;
    localparam int unsigned NO_CHANGE = 2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_A;
    logic              wr_B;
    logic              same_addr;
    logic [DATA_W-1:0] old_A;
    logic [DATA_W-1:0] old_B;
    logic [DATA_W-1:0] merged_A;
    logic [DATA_W-1:0] merged_B;
    logic [DATA_W-1:0] merged_AB;

    logic [DATA_W-1:0] s1_q_A;
    logic [DATA_W-1:0] s1_q_B;
    logic              s1_v_A;
    logic              s1_v_B;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] wdata,
        input logic [NBYTES-1:0] be
    );
        logic [DATA_W-1:0] res;
        res = base;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        wr_A      = en_A & wr_en_A;
        wr_B      = en_B & wr_en_B;
        same_addr = (addr_A == addr_B);
        old_A     = mem[addr_A];
        old_B     = mem[addr_B];
        merged_A  = merge_bytes(old_A, data_A, be_A);
        merged_B  = merge_bytes(old_B, data_B, be_B);
        // B bytes first, then A on top: A owns any byte both ports enable
        merged_AB = merge_bytes(merge_bytes(old_A, data_B, be_B), data_A, be_A);
    end

    // Memory shares the reset block only so that accesses during reset are dropped;
    // its contents are never cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q_A  <= '0;
            s1_q_B  <= '0;
            s1_v_A  <= 1'b0;
            s1_v_B  <= 1'b0;
            coll_ww <= 1'b0;
            coll_rw <= 1'b0;
        end else begin
            if (wr_A && wr_B && same_addr) begin
                mem[addr_A] <= merged_AB;
            end else begin
                if (wr_A) begin
                    mem[addr_A] <= merged_A;
                end
                if (wr_B) begin
                    mem[addr_B] <= merged_B;
                end
            end

            if (en_A && (!wr_en_A || RD_MODE != NO_CHANGE)) begin
                s1_v_A <= 1'b1;
                s1_q_A <= (wr_en_A && RD_MODE == WR_FIRST) ? merged_A : old_A;
            end else begin
                s1_v_A <= 1'b0;
            end

            if (en_B && (!wr_en_B || RD_MODE != NO_CHANGE)) begin
                s1_v_B <= 1'b1;
                s1_q_B <= (wr_en_B && RD_MODE == WR_FIRST) ? merged_B : old_B;
            end else begin
                s1_v_B <= 1'b0;
            end

            coll_ww <= en_A & en_B & wr_en_A & wr_en_B & same_addr;
            coll_rw <= en_A & en_B & (wr_en_A ^ wr_en_B) & same_addr;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_A       <= '0;
                    q_B       <= '0;
                    q_valid_A <= 1'b0;
                    q_valid_B <= 1'b0;
                end else begin
                    q_A       <= s1_q_A;
                    q_B       <= s1_q_B;
                    q_valid_A <= s1_v_A;
                    q_valid_B <= s1_v_B;
                end
            end
        end else begin : g_no_out_reg
            always_comb begin
                q_A       = s1_q_A;
                q_B       = s1_q_B;
                q_valid_A = s1_v_A;
                q_valid_B = s1_v_B;
            end
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Bench for dual_port_ram_param: four configurations driven by shared stimulus,
// checked against a word-level memory model with per-configuration output latency.
module tb_dual_port_ram_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b, wr_a, wr_b;
    logic [3:0]  be_a, be_b;
    logic [5:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;

    logic [31:0] qa_p [3];
    logic [31:0] qb_p [3];
    logic        va_p [3];
    logic        vb_p [3];
    logic        cww_p [3];
    logic        crw_p [3];
    logic [7:0]  qa_def, qb_def;
    logic        va_def, vb_def, cww_def, crw_def;

    // index 0: read-first, 1: write-first + out reg, 2: no-change, 3: all defaults
    logic [31:0] qa [4];
    logic [31:0] qb [4];
    logic        va [4];
    logic        vb [4];
    logic        cww [4];
    logic        crw [4];

    logic [31:0] mem [64];
    logic [31:0] eqa [4];
    logic [31:0] eqb [4];
    logic        eva [4];
    logic        evb [4];
    logic        ecww, ecrw;
    logic [31:0] sh_qa, sh_qb;
    logic        sh_va, sh_vb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dual_port_ram_param #(.DATA_W(32), .ADDR_W(6), .RD_MODE(0), .OUT_REG(0)) u_rf (
        .clk(clk), .rst_n(rst_n), .en_A(en_a), .en_B(en_b), .wr_en_A(wr_a), .wr_en_B(wr_b),
        .be_A(be_a), .be_B(be_b), .addr_A(addr_a), .addr_B(addr_b), .data_A(data_a), .data_B(data_b),
        .q_A(qa_p[0]), .q_B(qb_p[0]), .q_valid_A(va_p[0]), .q_valid_B(vb_p[0]),
        .coll_ww(cww_p[0]), .coll_rw(crw_p[0]));

    dual_port_ram_param #(.DATA_W(32), .ADDR_W(6), .RD_MODE(1), .OUT_REG(1)) u_wf (
        .clk(clk), .rst_n(rst_n), .en_A(en_a), .en_B(en_b), .wr_en_A(wr_a), .wr_en_B(wr_b),
        .be_A(be_a), .be_B(be_b), .addr_A(addr_a), .addr_B(addr_b), .data_A(data_a), .data_B(data_b),
        .q_A(qa_p[1]), .q_B(qb_p[1]), .q_valid_A(va_p[1]), .q_valid_B(vb_p[1]),
        .coll_ww(cww_p[1]), .coll_rw(crw_p[1]));

    dual_port_ram_param #(.DATA_W(32), .ADDR_W(6), .RD_MODE(2), .OUT_REG(0)) u_nc (
        .clk(clk), .rst_n(rst_n), .en_A(en_a), .en_B(en_b), .wr_en_A(wr_a), .wr_en_B(wr_b),
        .be_A(be_a), .be_B(be_b), .addr_A(addr_a), .addr_B(addr_b), .data_A(data_a), .data_B(data_b),
        .q_A(qa_p[2]), .q_B(qb_p[2]), .q_valid_A(va_p[2]), .q_valid_B(vb_p[2]),
        .coll_ww(cww_p[2]), .coll_rw(crw_p[2]));

    dual_port_ram_param u_def (
        .clk(clk), .rst_n(rst_n), .en_A(en_a), .en_B(en_b), .wr_en_A(wr_a), .wr_en_B(wr_b),
        .be_A(be_a[0:0]), .be_B(be_b[0:0]), .addr_A({2'b00, addr_a}), .addr_B({2'b00, addr_b}),
        .data_A(data_a[7:0]), .data_B(data_b[7:0]),
        .q_A(qa_def), .q_B(qb_def), .q_valid_A(va_def), .q_valid_B(vb_def),
        .coll_ww(cww_def), .coll_rw(crw_def));

    always_comb begin
        for (int d = 0; d < 3; d++) begin
            qa[d]  = qa_p[d];
            qb[d]  = qb_p[d];
            va[d]  = va_p[d];
            vb[d]  = vb_p[d];
            cww[d] = cww_p[d];
            crw[d] = crw_p[d];
        end
        qa[3]  = {24'h0, qa_def};
        qb[3]  = {24'h0, qb_def};
        va[3]  = va_def;
        vb[3]  = vb_def;
        cww[3] = cww_def;
        crw[3] = crw_def;
    end

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            eqa[d] = '0;
            eqb[d] = '0;
            eva[d] = 1'b0;
            evb[d] = 1'b0;
        end
        sh_qa = '0;
        sh_qb = '0;
        sh_va = 1'b0;
        sh_vb = 1'b0;
        ecww  = 1'b0;
        ecrw  = 1'b0;
    endtask

    // Advances the reference by one accepted clock edge using the current inputs.
    task automatic model_step();
        logic [31:0] old_a, old_b, new_a, new_b;
        logic [31:0] ra [3];
        logic [31:0] rb [3];
        logic        rva [3];
        logic        rvb [3];
        old_a = mem[addr_a];
        old_b = mem[addr_b];
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < 4; i++) begin
            if (be_a[i]) new_a[8*i +: 8] = data_a[8*i +: 8];
            if (be_b[i]) new_b[8*i +: 8] = data_b[8*i +: 8];
        end
        for (int m = 0; m < 3; m++) begin
            rva[m] = 1'b0; ra[m] = '0;
            rvb[m] = 1'b0; rb[m] = '0;
            if (en_a && !wr_a) begin rva[m] = 1'b1; ra[m] = old_a; end
            if (en_b && !wr_b) begin rvb[m] = 1'b1; rb[m] = old_b; end
        end
        if (en_a && wr_a) begin
            rva[0] = 1'b1; ra[0] = old_a;
            rva[1] = 1'b1; ra[1] = new_a;
        end
        if (en_b && wr_b) begin
            rvb[0] = 1'b1; rb[0] = old_b;
            rvb[1] = 1'b1; rb[1] = new_b;
        end
        if (en_b && wr_b)
            for (int i = 0; i < 4; i++) if (be_b[i]) mem[addr_b][8*i +: 8] = data_b[8*i +: 8];
        if (en_a && wr_a)
            for (int i = 0; i < 4; i++) if (be_a[i]) mem[addr_a][8*i +: 8] = data_a[8*i +: 8];
        ecww = en_a && en_b && wr_a && wr_b && (addr_a == addr_b);
        ecrw = en_a && en_b && (wr_a != wr_b) && (addr_a == addr_b);
        eva[0] = rva[0]; if (rva[0]) eqa[0] = ra[0];
        evb[0] = rvb[0]; if (rvb[0]) eqb[0] = rb[0];
        eva[2] = rva[2]; if (rva[2]) eqa[2] = ra[2];
        evb[2] = rvb[2]; if (rvb[2]) eqb[2] = rb[2];
        eqa[1] = sh_qa; eva[1] = sh_va;
        eqb[1] = sh_qb; evb[1] = sh_vb;
        sh_va = rva[1]; if (rva[1]) sh_qa = ra[1];
        sh_vb = rvb[1]; if (rvb[1]) sh_qb = rb[1];
        eqa[3] = eqa[2] & 32'hFF; eva[3] = eva[2];
        eqb[3] = eqb[2] & 32'hFF; evb[3] = evb[2];
    endtask

    task automatic drive(input logic ea, input logic wa, input logic [5:0] aa, input logic [31:0] da,
                         input logic [3:0] ba, input logic eb, input logic wb, input logic [5:0] ab,
                         input logic [31:0] db, input logic [3:0] bb);
        en_a = ea; wr_a = wa; addr_a = aa; data_a = da; be_a = ba;
        en_b = eb; wr_b = wb; addr_b = ab; data_b = db; be_b = bb;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'h0, 32'h0, 4'h0, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        for (int s = 0; s < 3; s++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (qa[d] !== eqa[d] || va[d] !== eva[d] || qb[d] !== eqb[d] || vb[d] !== evb[d] || cww[d] !== ecww || crw[d] !== ecrw) begin
                    failures++;
                    $display("FAIL reset dut%0d got qa=%h va=%b qb=%h vb=%b ww=%b rw=%b exp qa=%h va=%b qb=%h vb=%b ww=%b rw=%b",
                             d, qa[d], va[d], qb[d], vb[d], cww[d], crw[d], eqa[d], eva[d], eqb[d], evb[d], ecww, ecrw);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b1, 6'(i), $urandom, 4'hF, 1'b1, 1'b1, 6'(i + 32), $urandom, 4'hF);
            tick();
        end
        drive(1'b1, 1'b0, 6'h00, 32'h0, 4'h0, 1'b1, 1'b0, 6'h20, 32'h0, 4'h0);
        tick();
        idle();
        tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (qa[d] !== eqa[d] || va[d] !== eva[d] || qb[d] !== eqb[d] || vb[d] !== evb[d] || cww[d] !== ecww || crw[d] !== ecrw) begin
                failures++;
                $display("FAIL fill dut%0d got qa=%h va=%b qb=%h vb=%b ww=%b rw=%b exp qa=%h va=%b qb=%h vb=%b ww=%b rw=%b",
                         d, qa[d], va[d], qb[d], vb[d], cww[d], crw[d], eqa[d], eva[d], eqb[d], evb[d], ecww, ecrw);
            end
        end
    endtask

    task automatic test_basic();
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: drive(1'b1, 1'b1, 6'h10, 32'h1234565A, 4'hF, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
                1: drive(1'b0, 1'b0, 6'h0, 32'h0, 4'h0, 1'b1, 1'b0, 6'h10, 32'h0, 4'h0);
                default: idle();
            endcase
            tick();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (qa[d] !== eqa[d] || va[d] !== eva[d] || qb[d] !== eqb[d] || vb[d] !== evb[d] || cww[d] !== ecww || crw[d] !== ecrw) begin
                    failures++;
                    $display("FAIL basic dut%0d got qa=%h va=%b qb=%h vb=%b ww=%b rw=%b exp qa=%h va=%b qb=%h vb=%b ww=%b rw=%b",
                             d, qa[d], va[d], qb[d], vb[d], cww[d], crw[d], eqa[d], eva[d], eqb[d], evb[d], ecww, ecrw);
                end
            end
            if (s == 1) begin
                checks++;
                if (qb[3] !== 32'h5A || vb[3] !== 1'b1 || qb[2] !== 32'h1234565A || vb[2] !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_lat1 got def=%h/%b nc=%h/%b exp 5a/1 1234565a/1", qb[3], vb[3], qb[2], vb[2]);
                end
            end
            if (s == 2) begin
                checks++;
                if (qb[1] !== 32'h1234565A || vb[1] !== 1'b1 || vb[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_lat2 got q=%h v=%b lat1v=%b exp 1234565a/1 0", qb[1], vb[1], vb[0]);
                end
            end
        end
    endtask

    task automatic test_byte_enable();
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: drive(1'b1, 1'b1, 6'h03, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
                1: drive(1'b1, 1'b1, 6'h03, 32'h11223344, 4'b0101, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
                2: drive(1'b1, 1'b0, 6'h03, 32'h0, 4'h0, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
                default: idle();
            endcase
            tick();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (qa[d] !== eqa[d] || va[d] !== eva[d] || qb[d] !== eqb[d] || vb[d] !== evb[d] || cww[d] !== ecww || crw[d] !== ecrw) begin
                    failures++;
                    $display("FAIL byte_en dut%0d got qa=%h va=%b qb=%h vb=%b ww=%b rw=%b exp qa=%h va=%b qb=%h vb=%b ww=%b rw=%b",
                             d, qa[d], va[d], qb[d], vb[d], cww[d], crw[d], eqa[d], eva[d], eqb[d], evb[d], ecww, ecrw);
                end
            end
            if (s == 2) begin
                checks++;
                if (qa[0] !== 32'hAA22CC44 || qa[2] !== 32'hAA22CC44 || qa[1] !== 32'hAA22CC44) begin
                    failures++;
                    $display("FAIL byte_en_merge got rf=%h nc=%h wf=%h exp aa22cc44", qa[0], qa[2], qa[1]);
                end
            end
        end
    endtask

    task automatic test_collisions();
        for (int s = 0; s < 9; s++) begin
            case (s)
                0: drive(1'b1, 1'b1, 6'h07, 32'h11111101, 4'b0001, 1'b1, 1'b1, 6'h07, 32'h22222202, 4'b0001);
                2: drive(1'b1, 1'b0, 6'h07, 32'h0, 4'h0, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
                3: drive(1'b1, 1'b1, 6'h07, 32'h0000AB00, 4'b0010, 1'b1, 1'b1, 6'h07, 32'h000000CD, 4'b0001);
                4: drive(1'b1, 1'b0, 6'h07, 32'h0, 4'h0, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
                5: drive(1'b1, 1'b1, 6'h09, 32'h99887766, 4'hF, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
                6: drive(1'b1, 1'b0, 6'h09, 32'h0, 4'h0, 1'b1, 1'b1, 6'h09, 32'h01020304, 4'hF);
                7: drive(1'b0, 1'b0, 6'h0, 32'h0, 4'h0, 1'b1, 1'b0, 6'h09, 32'h0, 4'h0);
                default: idle();
            endcase
            tick();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (qa[d] !== eqa[d] || va[d] !== eva[d] || qb[d] !== eqb[d] || vb[d] !== evb[d] || cww[d] !== ecww || crw[d] !== ecrw) begin
                    failures++;
                    $display("FAIL collision dut%0d got qa=%h va=%b qb=%h vb=%b ww=%b rw=%b exp qa=%h va=%b qb=%h vb=%b ww=%b rw=%b",
                             d, qa[d], va[d], qb[d], vb[d], cww[d], crw[d], eqa[d], eva[d], eqb[d], evb[d], ecww, ecrw);
                end
            end
            if (s == 0 || s == 3) begin
                checks++;
                if (cww[0] !== 1'b1 || cww[3] !== 1'b1 || crw[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL coll_ww_pulse got ww=%b def_ww=%b rw=%b exp 1 1 0", cww[0], cww[3], crw[0]);
                end
            end
            if (s == 1) begin
                checks++;
                if (cww[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL coll_ww_clear got %b exp 0", cww[0]);
                end
            end
            if (s == 2) begin
                checks++;
                if (qa[0][7:0] !== 8'h01 || qa[3] !== 32'h01) begin
                    failures++;
                    $display("FAIL ww_a_wins got %h def=%h exp low byte 01", qa[0], qa[3]);
                end
            end
            if (s == 4) begin
                checks++;
                if (qa[0][15:0] !== 16'hABCD || qa[3] !== 32'hCD) begin
                    failures++;
                    $display("FAIL ww_merge got %h def=%h exp low half abcd, def cd", qa[0], qa[3]);
                end
            end
            if (s == 6) begin
                checks++;
                if (qa[0] !== 32'h99887766 || crw[0] !== 1'b1 || cww[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL rw_old_word got q=%h rw=%b ww=%b exp 99887766 1 0", qa[0], crw[0], cww[0]);
                end
            end
            if (s == 7) begin
                checks++;
                if (qb[0] !== 32'h01020304 || crw[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL rw_after got q=%h rw=%b exp 01020304 0", qb[0], crw[0]);
                end
            end
        end
    endtask

    task automatic test_rd_mode();
        logic [31:0] prev;
        prev = mem[0];
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: drive(1'b1, 1'b0, 6'h00, 32'h0, 4'h0, 1'b1, 1'b1, 6'h05, 32'h33333333, 4'hF);
                2: drive(1'b1, 1'b1, 6'h05, 32'h44444444, 4'hF, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
                default: idle();
            endcase
            tick();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (qa[d] !== eqa[d] || va[d] !== eva[d] || qb[d] !== eqb[d] || vb[d] !== evb[d] || cww[d] !== ecww || crw[d] !== ecrw) begin
                    failures++;
                    $display("FAIL rd_mode dut%0d got qa=%h va=%b qb=%h vb=%b ww=%b rw=%b exp qa=%h va=%b qb=%h vb=%b ww=%b rw=%b",
                             d, qa[d], va[d], qb[d], vb[d], cww[d], crw[d], eqa[d], eva[d], eqb[d], evb[d], ecww, ecrw);
                end
            end
            if (s == 2) begin
                checks++;
                if (qa[0] !== 32'h33333333 || va[0] !== 1'b1 || qa[2] !== prev || va[2] !== 1'b0 ||
                    qa[3] !== (prev & 32'hFF) || va[3] !== 1'b0) begin
                    failures++;
                    $display("FAIL rd_mode_write got rf=%h/%b nc=%h/%b def=%h/%b exp 33333333/1 %h/0 %h/0",
                             qa[0], va[0], qa[2], va[2], qa[3], va[3], prev, prev & 32'hFF);
                end
            end
            if (s == 3) begin
                checks++;
                if (qa[1] !== 32'h44444444 || va[1] !== 1'b1 || va[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL rd_mode_wf got wf=%h/%b rfv=%b exp 44444444/1 0", qa[1], va[1], va[0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [3];
        for (int i = 0; i < 3; i++) want[i] = mem[i];
        for (int s = 0; s < 6; s++) begin
            if (s < 3) drive(1'b1, 1'b0, 6'(s), 32'h0, 4'h0, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
            else idle();
            tick();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (qa[d] !== eqa[d] || va[d] !== eva[d] || qb[d] !== eqb[d] || vb[d] !== evb[d] || cww[d] !== ecww || crw[d] !== ecrw) begin
                    failures++;
                    $display("FAIL b2b dut%0d got qa=%h va=%b qb=%h vb=%b ww=%b rw=%b exp qa=%h va=%b qb=%h vb=%b ww=%b rw=%b",
                             d, qa[d], va[d], qb[d], vb[d], cww[d], crw[d], eqa[d], eva[d], eqb[d], evb[d], ecww, ecrw);
                end
            end
            if (s >= 1 && s <= 3) begin
                checks++;
                if (qa[1] !== want[s-1] || va[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_stream step%0d got %h/%b exp %h/1", s, qa[1], va[1], want[s-1]);
                end
            end else begin
                checks++;
                if (va[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_gap step%0d got v=%b exp 0", s, va[1]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7)),
                  $urandom, 4'($urandom),
                  1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7)),
                  $urandom, 4'($urandom));
            tick();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (qa[d] !== eqa[d] || va[d] !== eva[d] || qb[d] !== eqb[d] || vb[d] !== evb[d] || cww[d] !== ecww || crw[d] !== ecrw) begin
                    failures++;
                    $display("FAIL random n%0d dut%0d got qa=%h va=%b qb=%h vb=%b ww=%b rw=%b exp qa=%h va=%b qb=%h vb=%b ww=%b rw=%b",
                             n, d, qa[d], va[d], qb[d], vb[d], cww[d], crw[d], eqa[d], eva[d], eqb[d], evb[d], ecww, ecrw);
                end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_midread();
        logic [31:0] keep9;
        keep9 = mem[9];
        for (int s = 0; s < 7; s++) begin
            case (s)
                0: begin
                    drive(1'b1, 1'b0, 6'h09, 32'h0, 4'h0, 1'b1, 1'b0, 6'h0C, 32'h0, 4'h0);
                    tick();
                end
                1: begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    model_reset();
                end
                2, 3: begin
                    drive(1'b1, 1'b1, 6'h09, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 6'h0C, 32'h0, 4'h0);
                    @(posedge clk);
                    #1;
                end
                4: begin
                    #2;
                    rst_n = 1'b1;
                    drive(1'b1, 1'b0, 6'h09, 32'h0, 4'h0, 1'b1, 1'b0, 6'h0C, 32'h0, 4'h0);
                    tick();
                end
                default: begin
                    idle();
                    tick();
                end
            endcase
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (qa[d] !== eqa[d] || va[d] !== eva[d] || qb[d] !== eqb[d] || vb[d] !== evb[d] || cww[d] !== ecww || crw[d] !== ecrw) begin
                    failures++;
                    $display("FAIL reset_mid step%0d dut%0d got qa=%h va=%b qb=%h vb=%b ww=%b rw=%b exp qa=%h va=%b qb=%h vb=%b ww=%b rw=%b",
                             s, d, qa[d], va[d], qb[d], vb[d], cww[d], crw[d], eqa[d], eva[d], eqb[d], evb[d], ecww, ecrw);
                end
            end
            if (s == 1) begin
                checks++;
                if (qa[1] !== 32'h0 || va[1] !== 1'b0 || qa[0] !== 32'h0 || va[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_async got wf=%h/%b rf=%h/%b exp 0/0 0/0", qa[1], va[1], qa[0], va[0]);
                end
            end
            if (s == 4) begin
                checks++;
                if (qa[0] !== keep9 || va[0] !== 1'b1 || va[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_release got rf=%h/%b wfv=%b exp %h/1 0", qa[0], va[0], va[1], keep9);
                end
            end
            if (s == 5) begin
                checks++;
                if (qa[1] !== keep9 || va[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_keep got wf=%h/%b exp %h/1", qa[1], va[1], keep9);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        test_reset();
        test_fill();
        test_basic();
        test_byte_enable();
        test_collisions();
        test_rd_mode();
        test_back_to_back();
        test_random();
        test_reset_midread();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
